// File: rtl/ber_pkg.sv
// Shared types and constants for the PRBS BER sequencing controller.
package ber_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_SYNC = 3'd2,
    ST_MEAS = 3'd3,
    ST_DONE = 3'd4,
    ST_FAIL = 3'd5
  } state_t;

  localparam int CNT_W_DEF = 48;
  localparam int CLR_LEN   = 2;
  localparam int RSYNC_W   = 8;

endpackage

// File: rtl/ber_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and increment-by-0/1.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (inc && cnt != '1)
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/ber_ctrl.sv
// Sequencer for the PRBS BER checker: reset, sync, lock confirm,
// windowed bit/error accumulation and host-facing status.
module ber_ctrl
  import ber_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int SYNC_TIMEOUT = 262144,
  parameter int LOCK_CONFIRM = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [31:0]      i_window,
  input  logic             i_bit_valid,
  input  logic             i_chk_lock,
  input  logic             i_chk_err,
  output logic             o_chk_rst,
  output logic             o_chk_en,
  output logic [CNT_W-1:0] o_bit_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [7:0]       o_resync_cnt,
  output logic             o_busy,
  output logic             o_locked,
  output logic             o_done,
  output logic             o_timeout
);

  localparam int SYNC_W = $clog2(SYNC_TIMEOUT + 1);
  localparam int CONF_W = $clog2(LOCK_CONFIRM + 1);
  localparam int CLR_W  = $clog2(CLR_LEN + 1);
  localparam int CW     = (CNT_W > 32) ? CNT_W : 32;

  state_t              state;
  logic [CLR_W-1:0]    clr_cnt;
  logic [CONF_W-1:0]   conf;
  logic [31:0]         window;
  logic [SYNC_W-1:0]   sync_cnt;

  logic start_ok;
  logic strobe;
  logic meas_ok;
  logic meas_drop;
  logic err_inc;
  logic sync_hit;
  logic sync_to;
  logic locked_in;
  logic win_hit;
  logic sync_clr;

  // A strobe on a stop cycle is never counted: stop wins.
  always_comb begin
    start_ok  = (state == ST_IDLE) && i_start && !i_stop;
    strobe    = i_bit_valid && !i_stop;
    meas_ok   = (state == ST_MEAS) && strobe && i_chk_lock;
    meas_drop = (state == ST_MEAS) && strobe && !i_chk_lock;
    err_inc   = meas_ok && i_chk_err;
    sync_hit  = (state == ST_SYNC) && strobe;
    locked_in = sync_hit && i_chk_lock &&
                (conf == CONF_W'(LOCK_CONFIRM - 1));
    sync_to   = sync_hit &&
                (sync_cnt == SYNC_W'(SYNC_TIMEOUT - 1));
    win_hit   = meas_ok && (window != '0) &&
                (CW'(o_bit_cnt) + CW'(1) == CW'(window));
    sync_clr  = start_ok || meas_drop;
  end

  sat_counter #(.W(CNT_W)) u_bit (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .inc (meas_ok),
    .cnt (o_bit_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .inc (err_inc),
    .cnt (o_err_cnt)
  );

  sat_counter #(.W(RSYNC_W)) u_rsync (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .inc (meas_drop),
    .cnt (o_resync_cnt)
  );

  sat_counter #(.W(SYNC_W)) u_sync (
    .clk (clk),
    .rst (rst),
    .clr (sync_clr),
    .inc (sync_hit),
    .cnt (sync_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      clr_cnt   <= '0;
      conf      <= '0;
      window    <= '0;
      o_chk_rst <= 1'b0;
      o_done    <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_stop && state != ST_IDLE) begin
        state     <= ST_IDLE;
        o_chk_rst <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start_ok) begin
              state     <= ST_CLR;
              o_chk_rst <= 1'b1;
              clr_cnt   <= '0;
              conf      <= '0;
              window    <= i_window;
              o_timeout <= 1'b0;
            end
          end
          ST_CLR: begin
            if (clr_cnt == CLR_W'(CLR_LEN - 1)) begin
              state     <= ST_SYNC;
              o_chk_rst <= 1'b0;
            end else begin
              clr_cnt <= clr_cnt + CLR_W'(1);
            end
          end
          ST_SYNC: begin
            if (locked_in) begin
              state <= ST_MEAS;
              conf  <= '0;
            end else if (sync_to) begin
              state     <= ST_FAIL;
              o_timeout <= 1'b1;
            end else if (sync_hit) begin
              conf <= i_chk_lock ? conf + CONF_W'(1) : '0;
            end
          end
          ST_MEAS: begin
            if (meas_drop) begin
              state     <= ST_CLR;
              o_chk_rst <= 1'b1;
              clr_cnt   <= '0;
              conf      <= '0;
            end else if (win_hit) begin
              state  <= ST_DONE;
              o_done <= 1'b1;
            end
          end
          ST_DONE: state <= ST_IDLE;
          ST_FAIL: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_chk_en = i_bit_valid &&
                    (state == ST_SYNC || state == ST_MEAS);
  assign o_busy   = (state != ST_IDLE);
  assign o_locked = (state == ST_MEAS);

endmodule

// File: tb/tb_ber_ctrl.sv
// Bench for ber_ctrl: behavioural model checked every cycle
// plus directed scenarios with literal expectations.
module tb_ber_ctrl;

  localparam int CNT_W = 48;
  localparam int TO    = 64;
  localparam int LC    = 16;

  localparam int M_IDLE = 0;
  localparam int M_CLR  = 1;
  localparam int M_SYNC = 2;
  localparam int M_MEAS = 3;
  localparam int M_DONE = 4;
  localparam int M_FAIL = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_start = 1'b0;
  logic             i_stop = 1'b0;
  logic [31:0]      i_window = '0;
  logic             i_bit_valid = 1'b0;
  logic             i_chk_lock = 1'b0;
  logic             i_chk_err = 1'b0;
  logic             o_chk_rst;
  logic             o_chk_en;
  logic [CNT_W-1:0] o_bit_cnt;
  logic [CNT_W-1:0] o_err_cnt;
  logic [7:0]       o_resync_cnt;
  logic             o_busy;
  logic             o_locked;
  logic             o_done;
  logic             o_timeout;

  int checks = 0;
  int errors = 0;

  // model state
  int     m_mode = M_IDLE;
  int     m_clr_left = 0;
  int     m_streak = 0;
  int     m_sync_bits = 0;
  longint m_bits = 0;
  longint m_errs = 0;
  int     m_rs = 0;
  longint m_win = 0;
  bit     m_to = 1'b0;

  int     done_cnt = 0;
  longint done_bits = 0;
  longint done_errs = 0;
  int     mb = 0;
  int     ns = 0;

  ber_ctrl #(
    .CNT_W        (CNT_W),
    .SYNC_TIMEOUT (TO),
    .LOCK_CONFIRM (LC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_stop       (i_stop),
    .i_window     (i_window),
    .i_bit_valid  (i_bit_valid),
    .i_chk_lock   (i_chk_lock),
    .i_chk_err    (i_chk_err),
    .o_chk_rst    (o_chk_rst),
    .o_chk_en     (o_chk_en),
    .o_bit_cnt    (o_bit_cnt),
    .o_err_cnt    (o_err_cnt),
    .o_resync_cnt (o_resync_cnt),
    .o_busy       (o_busy),
    .o_locked     (o_locked),
    .o_done       (o_done),
    .o_timeout    (o_timeout)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Compare DUT against the model, then advance the model
  // with the inputs the next rising edge will sample.
  initial forever begin
    @(negedge clk);
    cmp("chk_en", longint'(o_chk_en),
        longint'(i_bit_valid &&
                 (m_mode == M_SYNC || m_mode == M_MEAS)));
    cmp("chk_rst", longint'(o_chk_rst),
        longint'(m_mode == M_CLR));
    cmp("busy", longint'(o_busy), longint'(m_mode != M_IDLE));
    cmp("locked", longint'(o_locked), longint'(m_mode == M_MEAS));
    cmp("done", longint'(o_done), longint'(m_mode == M_DONE));
    cmp("timeout", longint'(o_timeout), longint'(m_to));
    cmp("bit_cnt", longint'(o_bit_cnt), m_bits);
    cmp("err_cnt", longint'(o_err_cnt), m_errs);
    cmp("resync_cnt", longint'(o_resync_cnt), longint'(m_rs));
    if (o_done) begin
      done_cnt++;
      done_bits = longint'(o_bit_cnt);
      done_errs = longint'(o_err_cnt);
    end
    if (rst) begin
      m_mode = M_IDLE;
      m_bits = 0;
      m_errs = 0;
      m_rs = 0;
      m_to = 1'b0;
      m_win = 0;
    end else if (i_stop && m_mode != M_IDLE) begin
      m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: if (i_start) begin
          m_bits = 0;
          m_errs = 0;
          m_rs = 0;
          m_to = 1'b0;
          m_win = longint'(i_window);
          m_mode = M_CLR;
          m_clr_left = 2;
          m_streak = 0;
          m_sync_bits = 0;
        end
        M_CLR: begin
          m_clr_left--;
          if (m_clr_left == 0) m_mode = M_SYNC;
        end
        M_SYNC: if (i_bit_valid) begin
          m_sync_bits++;
          m_streak = i_chk_lock ? m_streak + 1 : 0;
          if (m_streak == LC) begin
            m_mode = M_MEAS;
          end else if (m_sync_bits == TO) begin
            m_mode = M_FAIL;
            m_to = 1'b1;
          end
        end
        M_MEAS: if (i_bit_valid) begin
          if (!i_chk_lock) begin
            if (m_rs < 255) m_rs++;
            m_mode = M_CLR;
            m_clr_left = 2;
            m_streak = 0;
            m_sync_bits = 0;
          end else begin
            m_bits++;
            if (i_chk_err) m_errs++;
            if (m_win != 0 && m_bits == m_win) m_mode = M_DONE;
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  task automatic tick(input logic s, input logic p, input logic v,
                      input logic l, input logic e);
    if (v && !p && !rst) begin
      if (m_mode == M_MEAS && l) mb++;
      if (m_mode == M_SYNC) ns++;
    end
    i_start = s;
    i_stop = p;
    i_bit_valid = v;
    i_chk_lock = l;
    i_chk_err = e;
    @(posedge clk);
    #1;
  endtask

  task automatic run_win1000(input string tag);
    int d0;
    d0 = done_cnt;
    i_window = 32'd1000;
    mb = 0;
    ns = 0;
    tick(1, 0, 0, 0, 0);
    cmp({tag, "_rst_c1"}, longint'(o_chk_rst), 1);
    tick(0, 0, 0, 0, 0);
    cmp({tag, "_rst_c2"}, longint'(o_chk_rst), 1);
    tick(0, 0, 0, 0, 0);
    cmp({tag, "_rst_off"}, longint'(o_chk_rst), 0);
    for (int k = 0; k < 3000 && done_cnt == d0; k++)
      tick(0, 0, 1, 1, (m_mode == M_MEAS) && (mb % 10 == 9));
    cmp({tag, "_sync_strobes"}, ns, 16);
    cmp({tag, "_done_pulses"}, done_cnt - d0, 1);
    cmp({tag, "_done_bits"}, done_bits, 1000);
    cmp({tag, "_done_errs"}, done_errs, 100);
    cmp({tag, "_busy_low"}, longint'(o_busy), 0);
    repeat (4) tick(0, 0, 0, 0, 0);
    cmp({tag, "_done_once"}, done_cnt - d0, 1);
    cmp({tag, "_bits_held"}, longint'(o_bit_cnt), 1000);
  endtask

  initial begin
    int d0;
    repeat (3) tick(0, 0, 0, 0, 0);
    cmp("reset_busy", longint'(o_busy), 0);
    cmp("reset_bits", longint'(o_bit_cnt), 0);
    rst = 1'b0;
    tick(0, 0, 0, 0, 0);

    run_win1000("win");

    // lock never asserted
    i_window = 32'd0;
    ns = 0;
    tick(1, 0, 0, 0, 0);
    for (int k = 0; k < 300; k++) begin
      tick(0, 0, 1, 0, 0);
      if (m_mode == M_IDLE) break;
    end
    cmp("to_strobes", ns, 64);
    cmp("to_flag", longint'(o_timeout), 1);
    cmp("to_bits", longint'(o_bit_cnt), 0);
    cmp("to_busy", longint'(o_busy), 0);

    // lock loss after 300 bits, then relock
    mb = 0;
    tick(1, 0, 0, 0, 0);
    cmp("start_clears_to", longint'(o_timeout), 0);
    for (int k = 0; k < 2000 && mb < 300; k++)
      tick(0, 0, k[0], 1, 0);
    tick(0, 0, 1, 0, 0);
    cmp("rs_cnt", longint'(o_resync_cnt), 1);
    cmp("rs_clr", longint'(o_chk_rst), 1);
    cmp("rs_bits", longint'(o_bit_cnt), 300);
    for (int k = 0; k < 200 && m_mode != M_MEAS; k++)
      tick(0, 0, 1, 1, 0);
    tick(0, 0, 1, 1, 0);
    cmp("rs_resume", longint'(o_bit_cnt), 301);
    tick(0, 1, 0, 0, 0);
    cmp("rs_stop", longint'(o_busy), 0);

    // continuous window ended by stop
    d0 = done_cnt;
    mb = 0;
    tick(1, 0, 0, 0, 0);
    for (int k = 0; k < 20000 && mb < 5000; k++)
      tick(0, 0, 1, 1, (k % 7) == 3);
    tick(0, 1, 0, 1, 0);
    cmp("cont_bits", longint'(o_bit_cnt), 5000);
    cmp("cont_busy", longint'(o_busy), 0);
    cmp("cont_nodone", done_cnt - d0, 0);

    // stop on final window strobe, start while busy
    d0 = done_cnt;
    i_window = 32'd20;
    mb = 0;
    tick(1, 0, 0, 0, 0);
    for (int k = 0; k < 200 && mb < 19; k++)
      tick(m_mode == M_MEAS && mb == 5, 0, 1, 1, 0);
    tick(0, 1, 1, 1, 0);
    cmp("stopfin_busy", longint'(o_busy), 0);
    cmp("stopfin_bits", longint'(o_bit_cnt), 19);
    repeat (3) tick(0, 0, 0, 0, 0);
    cmp("stopfin_nodone", done_cnt - d0, 0);

    // reset in MEAS
    i_window = 32'd0;
    mb = 0;
    tick(1, 0, 0, 0, 0);
    for (int k = 0; k < 200 && mb < 50; k++)
      tick(0, 0, 1, 1, (k % 5) == 0);
    cmp("pre_rst_locked", longint'(o_locked), 1);
    rst = 1'b1;
    tick(0, 0, 0, 0, 0);
    cmp("rst_bits", longint'(o_bit_cnt), 0);
    cmp("rst_errs", longint'(o_err_cnt), 0);
    cmp("rst_busy", longint'(o_busy), 0);
    cmp("rst_locked", longint'(o_locked), 0);
    cmp("rst_chk_rst", longint'(o_chk_rst), 0);
    rst = 1'b0;
    tick(0, 0, 0, 0, 0);
    run_win1000("again");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
